vector_cmd_exec: RTL and testbench

//  Responder end of the point-command handshake (x, y, draw, jump, ready) issued by the top-level sequencer.
//  It accepts one command when ready is high and executes it on the beam DAC outputs.

---
 rtl/vector_cmd_exec_if.sv | 14 +
 rtl/vector_cmd_exec.sv | 160 ++++++++++++++++
 tb/tb_vector_cmd_exec.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_cmd_exec_if.sv
// Point-command handshake between the top-level sequencer (master) and the
// vector command executor (slave).
interface vector_cmd_exec_if #(
    parameter int W = 12
);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         draw;
    logic         jump;
    logic         ready;

    modport master (output x, y, draw, jump, input ready);
    modport slave  (input x, y, draw, jump, output ready);
endinterface

// File: rtl/vector_cmd_exec.sv
// Executes one draw (Bresenham line, beam on) or jump (blanked move + settle)
// command at a time on the beam DAC outputs.
module vector_cmd_exec #(
    parameter int W             = 12,
    parameter int STEP_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_cmd_exec_if.slave       cmd,
    output logic [W-1:0]           dac_x,
    output logic [W-1:0]           dac_y,
    output logic                   beam_on
);

    typedef enum logic [1:0] {IDLE, SETUP, STEP, SETTLE} state_t;

    localparam int CNT_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] STEP_LOAD   = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [W-1:0]  ONE         = W'(1);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                beam_q, beam_d;
    logic [W-1:0]        dac_x_q, dac_x_d;
    logic [W-1:0]        dac_y_q, dac_y_d;
    logic [W-1:0]        tx_q, tx_d;
    logic [W-1:0]        ty_q, ty_d;
    logic signed [W+1:0] dx_q, dx_d;
    logic signed [W+1:0] dy_q, dy_d;
    logic signed [W+1:0] err_q, err_d;
    logic                sx_neg_q, sx_neg_d;
    logic                sy_neg_q, sy_neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic signed [W+1:0] diff_x, diff_y;
    logic signed [W+2:0] e2, dx_e, dy_e;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        state_d  = state_q;
        ready_d  = ready_q;
        beam_d   = beam_q;
        dac_x_d  = dac_x_q;
        dac_y_d  = dac_y_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        cnt_d    = cnt_q;

        diff_x = $signed({2'b00, tx_q}) - $signed({2'b00, dac_x_q});
        diff_y = $signed({2'b00, ty_q}) - $signed({2'b00, dac_y_q});
        e2     = {err_q, 1'b0};
        dx_e   = {dx_q[W+1], dx_q};
        dy_e   = {dy_q[W+1], dy_q};

        unique case (state_q)
            IDLE: begin
                if (ready_q && (cmd.draw || cmd.jump)) begin
                    tx_d    = cmd.x;
                    ty_d    = cmd.y;
                    ready_d = 1'b0;
                    if (cmd.jump) begin
                        dac_x_d = cmd.x;
                        dac_y_d = cmd.y;
                        beam_d  = 1'b0;
                        cnt_d   = SETTLE_LOAD;
                        state_d = SETTLE;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                // dy is kept negative so both Bresenham tests compare e2 directly.
                sx_neg_d = diff_x[W+1];
                sy_neg_d = diff_y[W+1];
                dx_d     = sx_neg_d ? -diff_x : diff_x;
                dy_d     = sy_neg_d ? diff_y : -diff_y;
                err_d    = dx_d + dy_d;
                beam_d   = 1'b1;
                cnt_d    = STEP_LOAD;
                state_d  = STEP;
            end
            STEP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (dac_x_q == tx_q && dac_y_q == ty_q) begin
                    beam_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = STEP_LOAD;
                    if (e2 >= dy_e) begin
                        err_d   = err_d + dy_q;
                        dac_x_d = sx_neg_q ? dac_x_q - ONE : dac_x_q + ONE;
                    end
                    if (e2 <= dx_e) begin
                        err_d   = err_d + dx_q;
                        dac_y_d = sy_neg_q ? dac_y_q - ONE : dac_y_q + ONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            beam_q   <= 1'b0;
            dac_x_q  <= '0;
            dac_y_q  <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            beam_q   <= beam_d;
            dac_x_q  <= dac_x_d;
            dac_y_q  <= dac_y_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd.ready = ready_q;
    assign dac_x     = dac_x_q;
    assign dac_y     = dac_y_q;
    assign beam_on   = beam_q;

endmodule

// File: tb/tb_vector_cmd_exec.sv
// Randomized bench for vector_cmd_exec: two instances (STEP_CYCLES 1 and 4)
// compared cycle by cycle against a point-list model of each command.
module tb_vector_cmd_exec;

    localparam int W        = 12;
    localparam int MAXC     = (1 << W) - 1;
    localparam int STEP_A   = 1;
    localparam int SETTLE_A = 16;
    localparam int STEP_B   = 4;
    localparam int SETTLE_B = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [W-1:0] x_in [2];
    logic [W-1:0] y_in [2];
    logic         draw_in [2];
    logic         jump_in [2];

    logic [W-1:0] dac_x_a, dac_y_a, dac_x_b, dac_y_b;
    logic         beam_a, beam_b;

    vector_cmd_exec_if #(.W(W)) bus_a ();
    vector_cmd_exec_if #(.W(W)) bus_b ();

    assign bus_a.x    = x_in[0];
    assign bus_a.y    = y_in[0];
    assign bus_a.draw = draw_in[0];
    assign bus_a.jump = jump_in[0];
    assign bus_b.x    = x_in[1];
    assign bus_b.y    = y_in[1];
    assign bus_b.draw = draw_in[1];
    assign bus_b.jump = jump_in[1];

    vector_cmd_exec #(.W(W), .STEP_CYCLES(STEP_A), .SETTLE_CYCLES(SETTLE_A)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .cmd     (bus_a),
        .dac_x   (dac_x_a),
        .dac_y   (dac_y_a),
        .beam_on (beam_a)
    );

    vector_cmd_exec #(.W(W), .STEP_CYCLES(STEP_B), .SETTLE_CYCLES(SETTLE_B)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .cmd     (bus_b),
        .dac_x   (dac_x_b),
        .dac_y   (dac_y_b),
        .beam_on (beam_b)
    );

    int checks = 0;
    int errors = 0;
    int cur_x [2];
    int cur_y [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got ready/beam/y/x=%h expected %h", tag, obs, exp);
        end
    endtask

    // Expected word layout: {ready, beam_on, dac_y, dac_x}.
    function automatic logic [63:0] pack(input bit r, input bit b, input int y, input int x);
        logic [W-1:0] yy, xx;
        yy = y[W-1:0];
        xx = x[W-1:0];
        return {{(64 - 2 - 2 * W){1'b0}}, r, b, yy, xx};
    endfunction

    function automatic logic [63:0] sample(input int d);
        if (d == 0) return {{(64 - 2 - 2 * W){1'b0}}, bus_a.ready, beam_a, dac_y_a, dac_x_a};
        return {{(64 - 2 - 2 * W){1'b0}}, bus_b.ready, beam_b, dac_y_b, dac_x_b};
    endfunction

    function automatic int clampc(input int v);
        if (v < 0) return 0;
        if (v > MAXC) return MAXC;
        return v;
    endfunction

    task automatic set_inputs(input int d, input int x, input int y, input bit dr, input bit jp);
        x_in[d]    = x[W-1:0];
        y_in[d]    = y[W-1:0];
        draw_in[d] = dr;
        jump_in[d] = jp;
    endtask

    // Issues one command at the current falling edge (DUT idle) and checks every
    // cycle until ready returns; abort_after>0 stops early, leaving the DUT busy.
    task automatic run_cmd(input int d, input int tx, input int ty, input bit dr, input bit jp,
                           input int abort_after);
        logic [63:0] exp_q [$];
        int step, settle;
        step   = (d == 0) ? STEP_A : STEP_B;
        settle = (d == 0) ? SETTLE_A : SETTLE_B;
        if (jp) begin
            for (int k = 0; k < settle; k++) exp_q.push_back(pack(0, 0, ty, tx));
        end else begin
            int x, y, dx, dy, sx, sy, err, e2;
            x   = cur_x[d];
            y   = cur_y[d];
            dx  = (tx > x) ? tx - x : x - tx;
            dy  = (ty > y) ? y - ty : ty - y;
            sx  = (x < tx) ? 1 : -1;
            sy  = (y < ty) ? 1 : -1;
            err = dx + dy;
            exp_q.push_back(pack(0, 0, y, x));
            forever begin
                for (int s = 0; s < step; s++) exp_q.push_back(pack(0, 1, y, x));
                if (x == tx && y == ty) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
        exp_q.push_back(pack(1, 0, ty, tx));

        set_inputs(d, tx, ty, dr, jp);
        @(posedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check($sformatf("dut%0d cmd(%0d,%0d,d%0d,j%0d) cyc%0d", d, tx, ty, dr, jp, k + 1),
                  sample(d), exp_q[k]);
            if ((abort_after != 0 && k + 1 == abort_after) || k == exp_q.size() - 1) begin
                set_inputs(d, 0, 0, 0, 0);
                if (k != exp_q.size() - 1) return;
            end else begin
                set_inputs(d, int'($urandom_range(0, MAXC)), int'($urandom_range(0, MAXC)),
                           1'($urandom), 1'($urandom));
            end
        end
        cur_x[d] = tx;
        cur_y[d] = ty;
    endtask

    task automatic random_cmds(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            int tx, ty;
            bit jp;
            jp = ($urandom_range(0, 3) == 0);
            if (jp && $urandom_range(0, 1) == 1) begin
                tx = int'($urandom_range(0, MAXC));
                ty = int'($urandom_range(0, MAXC));
            end else begin
                tx = clampc(cur_x[d] + int'($urandom_range(0, 80)) - 40);
                ty = clampc(cur_y[d] + int'($urandom_range(0, 80)) - 40);
            end
            run_cmd(d, tx, ty, !jp || ($urandom_range(0, 1) == 1), jp, 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            set_inputs(d, 0, 0, 0, 0);
            cur_x[d] = 0;
            cur_y[d] = 0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_a", sample(0), pack(1, 0, 0, 0));
        check("reset_b", sample(1), pack(1, 0, 0, 0));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_a", sample(0), pack(1, 0, 0, 0));
            check("idle_b", sample(1), pack(1, 0, 0, 0));
        end

        // Reset abandons a long line mid-flight.
        run_cmd(1, MAXC, MAXC, 1, 0, 30);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midline_reset_b", sample(1), pack(1, 0, 0, 0));
        check("midline_reset_a", sample(0), pack(1, 0, 0, 0));
        for (int d = 0; d < 2; d++) begin
            cur_x[d] = 0;
            cur_y[d] = 0;
        end

        run_cmd(0, 3, 1, 1, 0, 0);
        run_cmd(0, 100, 200, 0, 1, 0);
        run_cmd(0, 100, 190, 1, 0, 0);
        run_cmd(0, 50, 50, 1, 1, 0);
        run_cmd(0, MAXC - 5, 3, 0, 1, 0);
        run_cmd(0, MAXC, 0, 1, 0, 0);
        run_cmd(0, 0, 0, 1, 0, 0);
        run_cmd(0, 0, MAXC, 1, 0, 0);
        run_cmd(0, 3, MAXC - 2, 1, 0, 0);
        random_cmds(0, 25);

        run_cmd(1, 7, 7, 0, 1, 0);
        run_cmd(1, 7, 7, 1, 0, 0);
        run_cmd(1, 0, 9, 1, 0, 0);
        run_cmd(1, MAXC, MAXC, 0, 1, 0);
        run_cmd(1, MAXC - 6, MAXC, 1, 0, 0);
        random_cmds(1, 15);

        repeat (3) @(negedge clk);
        check("end_idle_a", sample(0), pack(1, 0, cur_y[0], cur_x[0]));
        check("end_idle_b", sample(1), pack(1, 0, cur_y[1], cur_x[1]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
